// File: rtl/exp3_unidade_controle_desafio_pkg.sv
// Shared definitions for the memory-game control unit: state codes and
// the sizing helper for the move timeout counter.
package exp3_unidade_controle_desafio_pkg;

    localparam int DB_ESTADO_W = 4;

    typedef enum logic [DB_ESTADO_W-1:0] {
        INICIAL     = 4'h0,
        PREPARA     = 4'h1,
        ESPERA      = 4'h2,
        REGISTRA    = 4'h4,
        COMPARA     = 4'h5,
        PROXIMO     = 4'h6,
        FIM_ACERTO  = 4'hA,
        FIM_ERRO    = 4'hE,
        FIM_TIMEOUT = 4'hF
    } estado_t;

    // Counter must hold values up to TIMEOUT_CICLOS; never narrower than 1 bit.
    function automatic int largura_contador(input int t);
        int w;
        w = (t <= 0) ? 1 : $clog2(t + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/exp3_unidade_controle_desafio_if.sv
// Control/status bundle between the control unit (master) and the datapath (slave).
interface exp3_unidade_controle_desafio_if;

    logic zeraC;
    logic contaC;
    logic zeraR;
    logic registraR;
    logic chavesIgualMemoria;
    logic fimC;

    modport master (
        output zeraC, contaC, zeraR, registraR,
        input  chavesIgualMemoria, fimC
    );

    modport slave (
        input  zeraC, contaC, zeraR, registraR,
        output chavesIgualMemoria, fimC
    );

endinterface

// File: rtl/exp3_unidade_controle_desafio_edge_detector.sv
// Rising-edge detector for button inputs: one-cycle pulse per press, however long it is held.
module exp3_unidade_controle_desafio_edge_detector (
    input  logic clock,
    input  logic reset,
    input  logic sinal,
    output logic pulso
);

    logic sinal_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            sinal_d <= 1'b0;
        end else begin
            sinal_d <= sinal;
        end
    end

    assign pulso = sinal & ~sinal_d;

endmodule

// File: rtl/exp3_unidade_controle_desafio.sv
// Moore control unit for the memory game: sequences one round of moves
// against the datapath and reports win, mismatch or move timeout.
module exp3_unidade_controle_desafio
    import exp3_unidade_controle_desafio_pkg::*;
#(
    parameter int TIMEOUT_CICLOS = 5000
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           iniciar,
    input  logic                           jogada,
    exp3_unidade_controle_desafio_if.master dp,
    output logic                           pronto,
    output logic                           acertou,
    output logic                           errou,
    output logic                           timeout,
    output logic [DB_ESTADO_W-1:0]         db_estado
);

    localparam int CNT_W = largura_contador(TIMEOUT_CICLOS);
    localparam logic [CNT_W-1:0] LIMITE =
        (TIMEOUT_CICLOS == 0) ? '0 : CNT_W'(TIMEOUT_CICLOS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    estado_t          estado;
    logic [CNT_W-1:0] cnt_espera;
    logic             jog_pulso;

    exp3_unidade_controle_desafio_edge_detector u_borda_jogada (
        .clock (clock),
        .reset (reset),
        .sinal (jogada),
        .pulso (jog_pulso)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            estado     <= INICIAL;
            cnt_espera <= '0;
        end else begin
            unique case (estado)
                INICIAL: begin
                    if (iniciar) estado <= PREPARA;
                end
                PREPARA: begin
                    cnt_espera <= '0;
                    estado     <= ESPERA;
                end
                ESPERA: begin
                    // Saturating so a disabled timeout can never wrap around.
                    if (cnt_espera != CNT_MAX) cnt_espera <= cnt_espera + CNT_W'(1);
                    if (jog_pulso) begin
                        estado <= REGISTRA;
                    end else if (TIMEOUT_CICLOS != 0 && cnt_espera == LIMITE) begin
                        estado <= FIM_TIMEOUT;
                    end
                end
                REGISTRA: begin
                    estado <= COMPARA;
                end
                COMPARA: begin
                    if (!dp.chavesIgualMemoria) begin
                        estado <= FIM_ERRO;
                    end else if (dp.fimC) begin
                        estado <= FIM_ACERTO;
                    end else begin
                        estado <= PROXIMO;
                    end
                end
                PROXIMO: begin
                    cnt_espera <= '0;
                    estado     <= ESPERA;
                end
                FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
                    if (iniciar) estado <= PREPARA;
                end
                default: begin
                    estado <= INICIAL;
                end
            endcase
        end
    end

    // Outputs depend on the state register alone.
    always_comb begin
        dp.zeraC     = 1'b0;
        dp.contaC    = 1'b0;
        dp.zeraR     = 1'b0;
        dp.registraR = 1'b0;
        pronto       = 1'b0;
        acertou      = 1'b0;
        errou        = 1'b0;
        timeout      = 1'b0;
        unique case (estado)
            PREPARA: begin
                dp.zeraC = 1'b1;
                dp.zeraR = 1'b1;
            end
            REGISTRA:   dp.registraR = 1'b1;
            PROXIMO:    dp.contaC    = 1'b1;
            FIM_ACERTO: begin
                pronto  = 1'b1;
                acertou = 1'b1;
            end
            FIM_ERRO: begin
                pronto = 1'b1;
                errou  = 1'b1;
            end
            FIM_TIMEOUT: begin
                pronto  = 1'b1;
                errou   = 1'b1;
                timeout = 1'b1;
            end
            default: ;
        endcase
    end

    assign db_estado = estado;

endmodule

// File: tb/tb_exp3_unidade_controle_desafio.sv
// Bench for the memory-game control unit: directed round scenarios plus random play,
// all compared each cycle against a behavioural model of the round rules.
module tb_exp3_unidade_controle_desafio;

    localparam int T = 8;

    logic       clock = 1'b0;
    logic       reset, iniciar, jogada;
    logic       pronto, acertou, errou, timeout;
    logic [3:0] db_estado;

    exp3_unidade_controle_desafio_if dp_if ();

    exp3_unidade_controle_desafio #(.TIMEOUT_CICLOS(T)) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .jogada    (jogada),
        .dp        (dp_if),
        .pronto    (pronto),
        .acertou   (acertou),
        .errou     (errou),
        .timeout   (timeout),
        .db_estado (db_estado)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    int n_conta = 0;
    int n_registra = 0;

    // Model of the round: current phase code, cycles spent waiting for a move, last button level.
    int m_estado = 0;
    int m_espera = 0;
    bit m_jog_ant = 1'b0;

    // Expected {zeraC,contaC,zeraR,registraR,pronto,acertou,errou,timeout,db_estado}.
    function automatic logic [11:0] saida_esperada(input int e);
        case (e)
            1:       return {8'b1010_0000, 4'h1};
            2:       return {8'b0000_0000, 4'h2};
            4:       return {8'b0001_0000, 4'h4};
            5:       return {8'b0000_0000, 4'h5};
            6:       return {8'b0100_0000, 4'h6};
            10:      return {8'b0000_1100, 4'hA};
            14:      return {8'b0000_1010, 4'hE};
            15:      return {8'b0000_1011, 4'hF};
            default: return 12'h000;
        endcase
    endfunction

    task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nome, act, exp);
        end
    endtask

    task automatic modelo(input bit rst, input bit ini, input bit jog, input bit ch, input bit fim);
        bit pressionou;
        int prox;
        pressionou = jog && !m_jog_ant;
        if (rst) begin
            m_estado  = 0;
            m_espera  = 0;
            m_jog_ant = 1'b0;
            return;
        end
        m_jog_ant = jog;
        prox = m_estado;
        case (m_estado)
            0: if (ini) prox = 1;
            1: begin m_espera = 0; prox = 2; end
            2: begin
                if (pressionou)            prox = 4;
                else if (m_espera == T - 1) prox = 15;
                m_espera++;
            end
            4: prox = 5;
            5: prox = !ch ? 14 : (fim ? 10 : 6);
            6: begin m_espera = 0; prox = 2; end
            10, 14, 15: if (ini) prox = 1;
            default: prox = 0;
        endcase
        m_estado = prox;
    endtask

    // One clock: drive on the falling edge, let the DUT sample, compare on the next falling edge.
    task automatic tick(input bit rst, input bit ini, input bit jog, input bit ch, input bit fim);
        reset   = rst;
        iniciar = ini;
        jogada  = jog;
        dp_if.chavesIgualMemoria = ch;
        dp_if.fimC = fim;
        modelo(rst, ini, jog, ch, fim);
        @(posedge clock);
        @(negedge clock);
        chk("saidas", 32'({dp_if.zeraC, dp_if.contaC, dp_if.zeraR, dp_if.registraR,
                           pronto, acertou, errou, timeout, db_estado}),
            32'(saida_esperada(m_estado)));
        if (dp_if.contaC === 1'b1)    n_conta++;
        if (dp_if.registraR === 1'b1) n_registra++;
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // Press, release, present the compare result; step through PROXIMO if the round continues.
    task automatic jogar(input bit ch, input bit fim);
        tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0, ch, fim);
        if (m_estado == 6) idle();
    endtask

    initial begin
        bit jog_r;
        reset = 1'b1; iniciar = 1'b0; jogada = 1'b0;
        dp_if.chavesIgualMemoria = 1'b1; dp_if.fimC = 1'b0;
        @(negedge clock);

        tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("reset_estado", 32'(db_estado), 32'h0);
        chk("reset_pronto", 32'(pronto), 32'h0);

        tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("prepara_estado", 32'(db_estado), 32'h1);
        chk("prepara_zera", 32'({dp_if.zeraC, dp_if.zeraR}), 32'h3);
        idle();
        chk("espera_estado", 32'(db_estado), 32'h2);
        chk("espera_zera", 32'({dp_if.zeraC, dp_if.zeraR}), 32'h0);

        n_conta = 0;
        for (int k = 1; k <= 16; k++) jogar(1'b1, k == 16);
        chk("acerto_conta", 32'(n_conta), 32'd15);
        chk("acerto_estado", 32'(db_estado), 32'hA);
        chk("acerto_flags", 32'({pronto, acertou, errou}), 32'b110);

        tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        idle();
        n_conta = 0;
        jogar(1'b1, 1'b0);
        jogar(1'b1, 1'b0);
        jogar(1'b0, 1'b0);
        chk("erro_conta", 32'(n_conta), 32'd2);
        chk("erro_estado", 32'(db_estado), 32'hE);
        chk("erro_flags", 32'({errou, timeout}), 32'b10);
        tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("reinicio_estado", 32'(db_estado), 32'h1);

        idle();
        repeat (7) idle();
        chk("timeout_ainda_espera", 32'(db_estado), 32'h2);
        idle();
        chk("timeout_estado", 32'(db_estado), 32'hF);
        chk("timeout_flags", 32'({pronto, errou, timeout}), 32'b111);

        tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        idle();
        repeat (7) idle();
        tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("prioridade_jogada", 32'(db_estado), 32'h4);
        idle();
        idle();
        idle();
        chk("volta_espera", 32'(db_estado), 32'h2);

        n_registra = 0;
        repeat (10) tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("segurado_registra", 32'(n_registra), 32'd1);
        chk("segurado_estado", 32'(db_estado), 32'h2);
        idle();
        tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("nova_pressao", 32'(db_estado), 32'h4);

        tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("iniciar_ignorado", 32'(db_estado), 32'h2);
        tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("em_compara", 32'(db_estado), 32'h5);
        tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("reset_compara", 32'({dp_if.zeraC, dp_if.contaC, dp_if.zeraR, dp_if.registraR,
                                  pronto, acertou, errou, timeout, db_estado}), 32'h0);

        jog_r = 1'b0;
        repeat (3000) begin
            if ($urandom_range(3) == 0) jog_r = ~jog_r;
            tick($urandom_range(63) == 0, $urandom_range(7) == 0, jog_r,
                 $urandom_range(7) != 0, $urandom_range(7) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
